uart_tx: RTL and testbench

Serial UART transmitter that pairs with the team's 16x-oversampled UART receiver. It accepts 8-bit bytes over a valid/ready handshake and buffers them in a small FIFO. Each byte is serialised as a standard frame: 1 start bit (0), 8 data bits LSB first, and STOP_BITS stop bits (1). The block sits between the CPU/MMIO side and the board's TX pin. `clk` runs at CLKS_PER_BIT × baud rate, so one bit period equals CLKS_PER_BIT cycles.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo.sv | 53 +++++
 rtl/uart_tx.sv | 112 +++++++++++
 tb/tb_uart_tx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and the transmitter/receiver state encoding.
package uart_pkg;

    localparam int   UART_DATA_BITS    = 8;
    localparam int   UART_CLKS_PER_BIT = 16;
    localparam logic UART_IDLE_LEVEL   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small circular byte buffer in front of the UART serialiser; head entry is presented combinationally.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // Push is judged against the registered count, so a push while full is refused even with a pop.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffered bytes are framed as start, 8 data bits LSB first, and STOP_BITS stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] d_tx,
    input  logic       vld_tx,
    output logic       rdy_tx,
    output logic       txd,
    output logic       busy,
    output logic [1:0] state_dbg
);

    localparam int BCW = $clog2(CLKS_PER_BIT);

    uart_state_e state;
    uart_state_e state_next;

    logic [UART_DATA_BITS-1:0] fifo_dout;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      pop;

    logic [UART_DATA_BITS-1:0] shift;
    logic [UART_DATA_BITS-1:0] shift_next;
    logic [BCW-1:0]            baud_cnt;
    logic [2:0]                bit_cnt;
    logic [0:0]                stop_cnt;
    logic                      baud_end;
    logic                      stop_last;
    logic                      txd_next;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (vld_tx),
        .pop   (pop),
        .din   (d_tx),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign baud_end  = (baud_cnt == BCW'(CLKS_PER_BIT - 1));
    assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));
    assign rdy_tx    = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty) state_next = START;
            START:   if (baud_end) state_next = DATA;
            DATA:    if (baud_end && bit_cnt == 3'd7) state_next = STOP;
            STOP:    if (baud_end && stop_last) state_next = fifo_empty ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    // The line level is computed from the next state so txd is a clean register output.
    always_comb begin
        pop        = 1'b0;
        shift_next = shift;
        txd_next   = UART_IDLE_LEVEL;
        case (state)
            IDLE:    pop = !fifo_empty;
            STOP:    pop = baud_end && stop_last && !fifo_empty;
            DATA:    if (baud_end) shift_next = {1'b1, shift[UART_DATA_BITS-1:1]};
            default: pop = 1'b0;
        endcase
        if (pop) shift_next = fifo_dout;
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[0];
            default: txd_next = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift    <= 8'hFF;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= '0;
            txd      <= UART_IDLE_LEVEL;
        end else begin
            shift <= shift_next;
            txd   <= txd_next;
            if (state == IDLE || baud_end) baud_cnt <= '0;
            else                           baud_cnt <= baud_cnt + 1'b1;
            if (state != DATA)  bit_cnt <= '0;
            else if (baud_end)  bit_cnt <= bit_cnt + 1'b1;
            if (state != STOP)  stop_cnt <= '0;
            else if (baud_end)  stop_cnt <= stop_last ? 1'b0 : stop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: default instance checked cycle by cycle and by a frame decoder, plus a 4-clk/2-stop instance.
module tb_uart_tx;
    import uart_pkg::*;

    logic       clk;
    logic       rstn;
    logic [7:0] d_tx0, d_tx1;
    logic       vld_tx0, vld_tx1;
    logic       rdy_tx0, rdy_tx1;
    logic       txd0, txd1;
    logic       busy0, busy1;
    logic [1:0] dbg0, dbg1;

    int checks = 0;
    int errors = 0;
    int rx_count = 0;
    logic mon_en = 1'b0;
    logic [7:0] exp_q[$];

    uart_tx dut0 (
        .clk(clk), .rstn(rstn), .d_tx(d_tx0), .vld_tx(vld_tx0), .rdy_tx(rdy_tx0),
        .txd(txd0), .busy(busy0), .state_dbg(dbg0)
    );

    uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(2)) dut1 (
        .clk(clk), .rstn(rstn), .d_tx(d_tx1), .vld_tx(vld_tx1), .rdy_tx(rdy_tx1),
        .txd(txd1), .busy(busy1), .state_dbg(dbg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with vld still high.
    task automatic push(input int sel, input logic [7:0] b);
        int guard = 0;
        if (sel == 0) begin d_tx0 = b; vld_tx0 = 1'b1; end
        else          begin d_tx1 = b; vld_tx1 = 1'b1; end
        while (((sel == 0) ? rdy_tx0 : rdy_tx1) !== 1'b1 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        chk("push_rdy", (sel == 0) ? rdy_tx0 : rdy_tx1, 1);
        @(posedge clk);
        if (sel == 0) exp_q.push_back(b);
        @(negedge clk);
    endtask

    // Starts on the negedge of frame cycle 0; compares every cycle against the ideal waveform.
    task automatic check_frame(input int sel, input logic [7:0] b, input int cpb, input int nstop);
        int bad = 0;
        int total = (9 + nstop) * cpb;
        int k;
        logic e, t, bz;
        for (int c = 0; c < total; c++) begin
            k = c / cpb;
            if (k == 0)      e = 1'b0;
            else if (k <= 8) e = b[k-1];
            else             e = 1'b1;
            t  = (sel == 0) ? txd0 : txd1;
            bz = (sel == 0) ? busy0 : busy1;
            if (t !== e || bz !== 1'b1) bad++;
            @(negedge clk);
        end
        chk($sformatf("frame_%0d_%02h", sel, b), bad, 0);
    endtask

    task automatic drain(input int limit);
        int guard = 0;
        while ((exp_q.size() != 0 || busy0 !== 1'b0) && guard < limit) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_q", exp_q.size(), 0);
        chk("drain_busy", busy0, 0);
    endtask

    // Receiver model: mid-bit sampling of dut0's line, popped against the scoreboard.
    initial begin
        logic prev;
        logic [7:0] r;
        logic [7:0] e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && rstn && prev === 1'b1 && txd0 === 1'b0) begin
                repeat (8) @(negedge clk);
                chk("rx_start", txd0, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clk);
                    r[i] = txd0;
                end
                repeat (16) @(negedge clk);
                chk("rx_stop", txd0, 1);
                rx_count++;
                chk("rx_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rx_byte", r, e);
                end
            end
            prev = txd0;
        end
    end

    initial begin
        int bad;
        rstn = 1'b0;
        d_tx0 = 8'h00; vld_tx0 = 1'b0;
        d_tx1 = 8'h00; vld_tx1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txd", txd0, 1);
        chk("rst_rdy", rdy_tx0, 1);
        chk("rst_busy", busy0, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("init_state", dbg0, IDLE);
        chk("init_txd", txd0, 1);
        mon_en = 1'b1;

        // Single byte: latency, waveform, busy fall 160 cycles after txd falls.
        push(0, 8'h55);
        vld_tx0 = 1'b0;
        chk("lat_still_idle", txd0, 1);
        @(negedge clk);
        check_frame(0, 8'h55, 16, 1);
        chk("single_busy_end", busy0, 0);
        chk("single_txd_end", txd0, 1);

        // Back-to-back frames with no idle gap.
        push(0, 8'hA5);
        push(0, 8'h3C);
        vld_tx0 = 1'b0;
        check_frame(0, 8'hA5, 16, 1);
        check_frame(0, 8'h3C, 16, 1);
        chk("b2b_busy_end", busy0, 0);

        // Overflow: 0x06 waits for a free slot.
        for (int i = 1; i <= 5; i++) push(0, 8'(i));
        chk("ovf_full_rdy", rdy_tx0, 0);
        chk("ovf_busy", busy0, 1);
        push(0, 8'h06);
        vld_tx0 = 1'b0;
        drain(3000);
        chk("rx_count_mid", rx_count, 9);

        // Second instance: 4 clocks per bit, two stop bits.
        push(1, 8'h80);
        vld_tx1 = 1'b0;
        @(negedge clk);
        check_frame(1, 8'h80, 4, 2);
        chk("p2_busy_end", busy1, 0);
        chk("p2_state_end", dbg1, IDLE);

        // Reset mid-frame with bytes still queued.
        mon_en = 1'b0;
        push(0, 8'h3C);
        push(0, 8'h77);
        vld_tx0 = 1'b0;
        repeat (40) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_mid_txd", txd0, 1);
        @(negedge clk);
        chk("rst_mid_busy", busy0, 0);
        chk("rst_mid_state", dbg0, IDLE);
        rstn = 1'b1;
        @(negedge clk);
        chk("rel_txd", txd0, 1);
        chk("rel_rdy", rdy_tx0, 1);
        chk("rel_busy", busy0, 0);
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            if (txd0 !== 1'b1 || busy0 !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("rst_flushed", bad, 0);
        exp_q.delete();
        mon_en = 1'b1;

        // Loopback of every byte value with random gaps in vld.
        for (int b = 0; b < 256; b++) begin
            push(0, 8'(b));
            if ($urandom_range(0, 3) == 0) begin
                vld_tx0 = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
            end
        end
        vld_tx0 = 1'b0;
        drain(50000);
        chk("rx_count_end", rx_count, 265);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
